// File: rtl/ttt_pkg.sv
// ttt_pkg: game command encoding and PS/2 set-2 scan codes shared by decoder and game logic
package ttt_pkg;

    typedef enum logic [2:0] {
        CMD_NONE       = 3'd0,
        CMD_RIGHT      = 3'd1,
        CMD_LEFT       = 3'd2,
        CMD_DOWN       = 3'd3,
        CMD_UP         = 3'd4,
        CMD_PLACE_TURN = 3'd5,
        CMD_PLACE_KEEP = 3'd6,
        CMD_NEW_GAME   = 3'd7
    } cmd_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    // Extended and plain pages are disjoint: E0 5A (keypad enter) is not a command.
    function automatic cmd_t map_cmd(input logic ext, input logic [7:0] b);
        if (!ext)
            return b == SC_R     ? CMD_NEW_GAME   :
                   b == SC_SPACE ? CMD_PLACE_TURN :
                   b == SC_ENTER ? CMD_PLACE_KEEP : CMD_NONE;
        return b == SC_RIGHT ? CMD_RIGHT :
               b == SC_LEFT  ? CMD_LEFT  :
               b == SC_UP    ? CMD_UP    :
               b == SC_DOWN  ? CMD_DOWN  : CMD_NONE;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO; a push while full succeeds when a pop frees the slot
module cmd_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_pop, do_push;

    always_comb begin
        empty   = wp == rp;
        full    = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rp[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= din;

endmodule

// File: rtl/ps2_cmd_decoder.sv
// ps2_cmd_decoder: PS/2 set-2 byte stream to game commands with prefix tracking and repeat suppression
module ps2_cmd_decoder
    import ttt_pkg::*;
#(
    parameter int FIFO_DEPTH     = 2,
    parameter int PREFIX_TIMEOUT = 1000000,
    parameter bit REPEAT_EN      = 1'b0
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic       read,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_drop,
    output logic [6:0] held
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam int         CW      = PREFIX_TIMEOUT > 2 ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PREFIX_TIMEOUT - 1);

    logic [1:0]    state, state_n;
    logic [7:0]    byte_q;
    logic          ext, brk;
    logic [CW-1:0] cnt;
    logic          push_q;
    cmd_t          push_cmd;
    cmd_t          m;
    logic          dec, is_pfx, hit, enq, is_held;
    logic [7:0]    held_x, onehot;
    logic [2:0]    head;
    logic          full, empty, pop;

    // The byte decodes during ACK, one cycle after capture; the push lands in the FIFO a cycle later.
    always_comb begin
        state_n = state == ST_IDLE && scan_ready  ? ST_ACK  :
                  state == ST_ACK                 ? ST_WAIT :
                  state == ST_WAIT && !scan_ready ? ST_IDLE : state;
        dec     = state == ST_ACK;
        is_pfx  = byte_q == SC_EXT || byte_q == SC_BRK;
        m       = map_cmd(ext, byte_q);
        hit     = dec && !is_pfx && m != CMD_NONE;
        held_x  = {held, 1'b0};
        is_held = held_x[m];
        onehot  = 8'd1 << m;
        enq     = hit && !brk && (REPEAT_EN || !is_held);
        read    = state == ST_ACK;
        pop     = !empty && cmd_ready;
        cmd_valid = !empty;
        cmd     = empty ? CMD_NONE : head;
        cmd_drop = push_q && full && !pop;
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            state    <= ST_IDLE;
            byte_q   <= '0;
            ext      <= 1'b0;
            brk      <= 1'b0;
            cnt      <= '0;
            push_q   <= 1'b0;
            push_cmd <= CMD_NONE;
            held     <= '0;
        end else begin
            state    <= state_n;
            push_q   <= enq;
            push_cmd <= m;
            if (state == ST_IDLE && scan_ready) byte_q <= scan_code;
            if (hit) held <= brk ? held & ~onehot[7:1] : held | onehot[7:1];
            if (dec && byte_q == SC_EXT) begin
                ext <= 1'b1;
                cnt <= '0;
            end else if (dec && byte_q == SC_BRK) begin
                brk <= 1'b1;
                cnt <= '0;
            end else if (dec) begin
                ext <= 1'b0;
                brk <= 1'b0;
                cnt <= '0;
            end else if (ext || brk) begin
                if (cnt == CNT_LAST) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(3)) u_fifo (
        .clk  (clock50),
        .rst  (reset),
        .push (push_q),
        .din  (push_cmd),
        .pop  (pop),
        .dout (head),
        .full (full),
        .empty(empty)
    );

endmodule
